// File: rtl/cpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_fetch_pkg
// Brief  : Shared defaults, types and helpers for the instruction fetch stage.
//          DEF_ADDR_W   - default ROM word-address width
//          DEF_DATA_W   - default instruction width
//          DEF_RESET_PC - byte PC fetched first after reset
//          INSTR_NOP_ZERO - ROM padding word (halts fetch when
//                           FETCH_HALT_ON_ZERO_EN is defined)
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_fetch_pkg;

  localparam int          DEF_ADDR_W     = 6;
  localparam int          DEF_DATA_W     = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP_ZERO = 32'h0000_0000;

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [31:0]           pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte PC (low two bits carry no meaning for fetch).
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage : cpu_fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : fetch_skid_buf
// Brief  : 2-entry FIFO with fall-through between the ROM return path and
//          decode. When empty, a pushed entry is presented on the output in
//          the same cycle and is only stored if it is not popped.
// Ports  : clk          - clock
//          rst_n        - asynchronous active-low reset
//          i_flush      - drop all stored entries (overrides push/pop storage)
//          i_push       - a returning entry is present this cycle
//          i_push_pc    - byte PC of the returning entry
//          i_push_instr - instruction word of the returning entry
//          i_pop        - consumer accepts the presented entry
//          o_valid      - an entry is presented
//          o_pc/o_instr - presented entry (zero when nothing is presented)
//          o_count      - number of stored entries (0..2)
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [31:0]       i_push_pc,
  input  logic [DATA_W-1:0] i_push_instr,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic [1:0]        o_count
);

  logic [31:0]       r_pc_mem    [2];
  logic [DATA_W-1:0] r_instr_mem [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic w_empty;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty  = (r_count == 2'd0);
  assign o_valid  = !w_empty || i_push;
  // Empty buffer, new word consumed immediately: it never needs storing.
  assign w_bypass = w_empty && i_push && i_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = i_pop && !w_empty;
  assign o_count  = r_count;

  always_comb begin
    o_pc    = '0;
    o_instr = '0;
    if (!w_empty) begin
      o_pc    = r_pc_mem[r_rd_ptr];
      o_instr = r_instr_mem[r_rd_ptr];
    end else if (i_push) begin
      o_pc    = i_push_pc;
      o_instr = i_push_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_pc_mem[r_wr_ptr]    <= i_push_pc;
        r_instr_mem[r_wr_ptr] <= i_push_instr;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Fetch stage driving a synchronous-read instruction ROM. Issues
//          word addresses, absorbs the 1-cycle ROM latency and presents
//          {pc, instruction} to decode over valid/ready, with branch
//          redirect/flush and a 2-entry buffer for full-rate streaming.
// Config : FETCH_HALT_ON_ZERO_EN - when defined, a returned all-zero word is
//          not delivered and fetch halts until redirect or reset.
// Ports  : clka           - clock (shared with the ROM)
//          rst_n          - asynchronous active-low reset
//          rom_addr       - ROM word address, sampled at posedge clka
//          rom_data       - ROM output, valid the cycle after rom_addr
//          redirect_valid - restart fetch at redirect_pc (single cycle)
//          redirect_pc    - byte target, bits [1:0] ignored
//          if_valid       - instruction available to decode
//          if_ready       - decode accepts
//          if_instr       - instruction word
//          if_pc          - byte PC of if_instr
//          if_halted      - fetch stopped on a zero word (0 when disabled)
// Rev    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          DATA_W   = DEF_DATA_W,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clka,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [31:0]       if_pc,
  output logic              if_halted
);

  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;

  logic [31:0] w_issue_pc;
  logic        w_issue;
  logic        w_pop;
  logic        w_push;
  logic        w_zero_ret;
  logic        w_halted;
  logic [1:0]  w_count;
  logic [2:0]  w_occ;

  // Redirect target goes straight to the ROM in the same cycle.
  assign w_issue_pc = redirect_valid ? align_pc(redirect_pc) : r_fetch_pc;
  assign rom_addr   = w_issue_pc[ADDR_W+1:2];

  assign w_pop = if_valid && if_ready;

  // Words that will be held after this cycle if nothing new is issued:
  // stored entries plus the returning word, minus the one decode takes.
  assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

`ifdef FETCH_HALT_ON_ZERO_EN
  logic r_halted;

  assign w_zero_ret = r_inflight && !r_halted &&
                      (rom_data == DATA_W'(INSTR_NOP_ZERO));
  assign w_halted   = r_halted;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_zero_ret) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign w_zero_ret = 1'b0;
  assign w_halted   = 1'b0;
`endif

  // The zero word itself is swallowed; it is the youngest word, so older
  // buffered entries still drain.
  assign w_push  = r_inflight && !w_zero_ret;
  assign w_issue = redirect_valid ||
                   (!w_halted && !w_zero_ret && (w_occ < 3'd2));

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= w_issue_pc + 32'd4;
        r_inflight_pc <= w_issue_pc;
      end
    end
  end

  fetch_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk          (clka),
    .rst_n        (rst_n),
    .i_flush      (redirect_valid),
    .i_push       (w_push),
    .i_push_pc    (r_inflight_pc),
    .i_push_instr (rom_data),
    .i_pop        (if_ready),
    .o_valid      (if_valid),
    .o_pc         (if_pc),
    .o_instr      (if_instr),
    .o_count      (w_count)
  );

  assign if_halted = w_halted;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed bench for instr_fetch_unit with a sequential-PC model
//          checked every cycle plus literal expectations per scenario.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int AW = 6;

  logic          clka = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          if_halted;

  logic [31:0] rom [64];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clka = ~clka;

  always @(posedge clka) rom_data <= rom[rom_addr];

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clka           (clka),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_halted      (if_halted)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: delivered PCs are strictly sequential ----------
  logic [31:0] m_pc = 32'h0;
  logic        pend_redir = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  logic        hold = 1'b0;
  logic [31:0] hold_pc = 32'h0;
  logic [31:0] hold_instr = 32'h0;
  int          idle = 0;

  always @(negedge clka) begin
    if (!rst_n) begin
      chk("cmp_rst_valid", 64'(if_valid), 64'd0);
      m_pc       = 32'h0;
      pend_redir = 1'b0;
      hold       = 1'b0;
      idle       = 0;
    end else begin
      if (pend_redir) begin
        chk("redir_fall_valid", 64'(if_valid), 64'd1);
        chk("redir_fall_pc", 64'(if_pc), 64'(pend_pc));
        pend_redir = 1'b0;
      end
      if (hold) begin
        chk("hold_valid", 64'(if_valid), 64'd1);
        chk("hold_pc", 64'(if_pc), 64'(hold_pc));
        chk("hold_instr", 64'(if_instr), 64'(hold_instr));
      end
      if (if_valid) begin
        chk("order_pc", 64'(if_pc), 64'(m_pc));
        chk("order_instr", 64'(if_instr), 64'(rom[m_pc[AW+1:2]]));
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("zero_not_delivered", 64'(if_instr != 32'h0), 64'd1);
`endif
        if (if_ready) m_pc = m_pc + 32'd4;
        idle = 0;
      end else if (!if_halted) begin
        idle++;
      end else begin
        idle = 0;
      end
      chk("no_stall", 64'(idle > 4), 64'd0);
`ifndef FETCH_HALT_ON_ZERO_EN
      chk("halted_tied_low", 64'(if_halted), 64'd0);
`endif
      hold       = if_valid && !if_ready && !redirect_valid;
      hold_pc    = if_pc;
      hold_instr = if_instr;
      if (redirect_valid) begin
        chk("redir_rom_addr", 64'(rom_addr), 64'(redirect_pc[AW+1:2]));
        m_pc       = redirect_pc & ~32'h3;
        pend_redir = 1'b1;
        pend_pc    = m_pc;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic smp();
    @(negedge clka);
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clka);
    #1;
    rst_n = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    rst_n = 1'b1;
    if_ready = rdy;
  endtask

  task automatic chk_out(input string name, input logic [31:0] pc,
                         input logic [31:0] instr);
    chk({name, "_valid"}, 64'(if_valid), 64'd1);
    chk({name, "_pc"}, 64'(if_pc), 64'(pc));
    chk({name, "_instr"}, 64'(if_instr), 64'(instr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1w [4];
    int          n_deliv;
    logic [31:0] last_pc;
    t1w[0] = 32'he3a00004;
    t1w[1] = 32'he3a01001;
    t1w[2] = 32'he3a02002;
    t1w[3] = 32'he3a0300a;
    for (int i = 0; i < 64; i++) rom[i] = 32'hE590_0000 | 32'(i);
    for (int i = 0; i < 4; i++) rom[i] = t1w[i];

    rst_n = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    smp();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_pc", 64'(if_pc), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_halted", 64'(if_halted), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);

    // T1: streaming after reset release
    cyc();
    rst_n = 1'b1;
    if_ready = 1'b1;
    smp();
    chk("t1_c1_valid", 64'(if_valid), 64'd0);
    chk("t1_c1_addr", 64'(rom_addr), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      chk_out("t1_stream", 32'(4 * k), t1w[k]);
      chk("t1_addr", 64'(rom_addr), 64'(k + 1));
    end

    // T2: back-pressure for 3 cycles after first accept
    do_reset(1'b1);
    smp();
    cyc();
    smp();
    chk_out("t2_first", 32'h0, 32'he3a00004);
    for (int k = 0; k < 3; k++) begin
      cyc();
      if_ready = 1'b0;
      smp();
      chk_out("t2_held", 32'h4, 32'he3a01001);
    end
    cyc();
    if_ready = 1'b1;
    smp();
    chk_out("t2_resume4", 32'h4, 32'he3a01001);
    cyc();
    smp();
    chk_out("t2_resume8", 32'h8, 32'he3a02002);
    cyc();
    smp();
    chk_out("t2_resumeC", 32'hC, 32'he3a0300a);

    // T3: fill the buffer, then redirect to 0x30
    for (int k = 0; k < 3; k++) begin
      cyc();
      if_ready = 1'b0;
      smp();
      chk_out("t3_fill", 32'h10, 32'hE590_0004);
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h30;
    smp();
    chk("t3_redir_addr", 64'(rom_addr), 64'h0C);
    cyc();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    smp();
    chk_out("t3_target", 32'h30, 32'hE590_000C);
    cyc();
    smp();
    chk_out("t3_next34", 32'h34, 32'hE590_000D);
    cyc();
    smp();
    chk_out("t3_next38", 32'h38, 32'hE590_000E);

    // T4: address wrap at the top of the ROM, then unaligned redirect
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'hF8;
    smp();
    chk("t4_addr62", 64'(rom_addr), 64'd62);
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk_out("t4_pcF8", 32'hF8, 32'hE590_003E);
    chk("t4_addr63", 64'(rom_addr), 64'd63);
    cyc();
    smp();
    chk_out("t4_pcFC", 32'hFC, 32'hE590_003F);
    chk("t4_addr0", 64'(rom_addr), 64'd0);
    cyc();
    smp();
    chk_out("t4_pc100", 32'h100, 32'he3a00004);
    chk("t4_addr1", 64'(rom_addr), 64'd1);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h33;
    smp();
    chk("t4_unaligned_addr", 64'(rom_addr), 64'h0C);
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk_out("t4_pc30", 32'h30, 32'hE590_000C);

    // T5: asynchronous reset mid-stream with if_ready toggling
    for (int k = 0; k < 6; k++) begin
      cyc();
      if_ready = (k % 2 == 0);
    end
    cyc();
    if_ready = 1'b1;
    chk("t5_pre_valid", 64'(if_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(if_valid), 64'd0);
    chk("t5_async_pc", 64'(if_pc), 64'd0);
    repeat (2) @(posedge clka);
    #1;
    rst_n = 1'b1;
    smp();
    chk("t5_c1_valid", 64'(if_valid), 64'd0);
    cyc();
    smp();
    chk_out("t5_restart", 32'h0, 32'he3a00004);

    // T6: zero word at index 9
    rom[9] = 32'h0;
    do_reset(1'b1);
    n_deliv = 0;
    last_pc = 32'hFFFF_FFFF;
    for (int k = 0; k < 16; k++) begin
      smp();
      if (if_valid && if_ready) begin
        n_deliv++;
        last_pc = if_pc;
      end
      cyc();
    end
    smp();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("t6_deliv_count", 64'(n_deliv), 64'd9);
    chk("t6_last_pc", 64'(last_pc), 64'h20);
    chk("t6_halted", 64'(if_halted), 64'd1);
    chk("t6_halt_valid", 64'(if_valid), 64'd0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    smp();
    cyc();
    redirect_valid = 1'b0;
    smp();
    chk("t6_unhalt", 64'(if_halted), 64'd0);
    chk_out("t6_resume", 32'h0, 32'he3a00004);
`else
    chk("t6_deliv_count", 64'(n_deliv), 64'd15);
    chk("t6_last_pc", 64'(last_pc), 64'h38);
    chk("t6_halted", 64'(if_halted), 64'd0);
    chk("t6_stream_valid", 64'(if_valid), 64'd1);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that drives the synchronous-read instruction ROM: issues word addresses, absorbs the ROM's 1-cycle read latency and presents {pc, instruction} to decode over a valid/ready handshake.
- Supports branch redirect with flush and full-throughput streaming under back-pressure via a 2-entry buffer.
- Sits between the PC/branch logic of the core and the ROM port (clka / addr / 32-bit data).

Parameters:
ADDR_W, 6, ROM word-address width (ROM depth = 2**ADDR_W words)
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, byte PC fetched first after reset

Ports:
clka  in  1  clock; ROM shares it
rst_n  in  1  asynchronous active-low reset
rom_addr  out  ADDR_W  word address to ROM, sampled by ROM at posedge clka
rom_data  in  DATA_W  ROM output, valid the cycle after rom_addr was presented
redirect_valid  in  1  single-cycle request to restart fetch at redirect_pc
redirect_pc  in  32  byte target; bits [1:0] ignored
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts; transfer when if_valid && if_ready
if_instr  out  DATA_W  instruction word
if_pc  out  32  byte PC of if_instr
if_halted  out  1  fetch stopped (see Optional Feature; tied 0 when absent)

Behaviour:
- Reset (async assert, sync deassert into clka domain by the system): fetch_pc=RESET_PC, inflight=0, buffer count=0, if_valid=0, if_instr=0, if_pc=0, if_halted=0; rom_addr=RESET_PC[ADDR_W+1:2].
- Address: rom_addr = redirect_valid ? redirect_pc[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2] (combinational mux, registered sources). Addresses wrap modulo 2**ADDR_W; fetch_pc increments by 4 modulo 2**32.
- Issue: a fetch issues in cycle n iff (count + inflight - pop) < 2, where pop = if_valid && if_ready. On issue: inflight<=1, inflight_pc<=issued pc, fetch_pc<=issued pc+4. Otherwise inflight<=0 and fetch_pc holds, so rom_addr is re-presented harmlessly.
- Return: in cycle n+1, rom_data belongs to inflight_pc when inflight=1.
- Output path: buffer empty and inflight=1 -> fall-through: if_valid=1, if_instr=rom_data, if_pc=inflight_pc. Not popped -> written to buffer. Buffer non-empty -> head entry presented; returning word appended at tail. Order strictly preserved.
- Latency: address issue to if_valid = 1 cycle. Steady-state throughput 1 instr/cycle with if_ready=1.
- Back-pressure: if_ready=0 holds if_valid, if_instr and if_pc stable until accepted. No word is ever dropped or duplicated. Max stored = 2.
- Redirect in cycle n:
  - Buffer flushed and inflight cancelled, so the ROM return in n+1 carries the redirect word only.
  - rom_addr = redirect target in cycle n; fetch_pc <= target+4.
  - if_valid is 0 during n+1 unless the new word arrives (fall-through), i.e. if_valid=1 in n+1 with if_pc=target&~3.
  - A handshake in cycle n still completes (decode consumed it). Redirect takes priority over issue and append.
- Redirect while halted: clears halt and resumes.
- Simultaneous pop + append with count=2: impossible by the issue rule. Pop + append with count=1: count stays 1.

Optional Feature:
- Macro FETCH_HALT_ON_ZERO_EN.
- With it: a returned word equal to 0 (ROM padding) is not delivered. if_halted<=1 the following cycle, issue stops, and inflight/buffer younger entries are discarded. Words before it drain normally. Only redirect_valid or reset clears the halt.
- Without it: zero words are ordinary instructions, and if_halted is constant 0.

Decomposition:
- Shared package cpu_fetch_pkg: ADDR_W/DATA_W defaults, RESET_PC, fetch-entry struct {pc[31:0], instr[DATA_W-1:0]}, INSTR_NOP_ZERO constant.
- One sub-module: fetch_skid_buf (2-entry FIFO with fall-through, flush, count output).

Test Plan:
- ROM words 0..3 = e3a00004, e3a01001, e3a02002, e3a0300a, if_ready=1 after reset release -> if_valid from cycle 2, pcs 0,4,8,C with those words on consecutive cycles, rom_addr 0,1,2,3.
- if_ready low 3 cycles after first accept -> if_pc=4 / e3a01001 held stable; no loss; resumes 8, C back-to-back.
- redirect_valid with redirect_pc=0x30 while buffer holds 2 -> next cycle if_valid=1, if_pc=0x30, rom_addr=0x0C in the redirect cycle; flushed words never appear.
- fetch_pc reaching 0xFC (rom_addr 63) -> next rom_addr 0, if_pc 0x100; redirect_pc=0x33 -> if_pc 0x30.
- Reset asserted mid-stream with if_ready toggling -> if_valid=0 immediately (async); after release, fetch restarts at RESET_PC.
- FETCH_HALT_ON_ZERO_EN defined, word 9=0 -> pcs 0..0x20 delivered, then if_halted=1 and no if_valid; redirect to 0 -> if_halted=0 and if_pc=0 delivered.
